// File: rtl/vram_fetch_arb_if.sv
// VRAM port and CPU req/ack port of the VRAM fetch arbiter, bundled together.
// The master side is the arbiter, and the slave side is the VRAM/CPU environment.
interface vram_fetch_arb_if;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic        vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (
    output vram_addr, vram_rd, vram_wr, vram_wdata, cpu_rdata, cpu_ack,
    input  vram_rdata, cpu_req, cpu_we, cpu_addr, cpu_wdata
  );

  modport slave (
    input  vram_addr, vram_rd, vram_wr, vram_wdata, cpu_rdata, cpu_ack,
    output vram_rdata, cpu_req, cpu_we, cpu_addr, cpu_wdata
  );
endinterface

// File: rtl/vram_fetch_arb.sv
// Single-port VRAM sequencer: fetches six plane bytes per character cell
// (double-buffered) and fits CPU reads and writes into the idle slots.
module vram_fetch_arb #(
  parameter int unsigned PLANE_BASE = 'h0000,
  parameter int unsigned PLANE_SIZE = 'h2000,
  parameter int unsigned NPLANES    = 6
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cell_start,
  input  logic        fetch_en,
  input  logic [12:0] cell_addr,
  vram_fetch_arb_if.master bus,
  output logic [7:0]  fg1,
  output logic [7:0]  fg2,
  output logic [7:0]  fg3,
  output logic [7:0]  bg1,
  output logic [7:0]  bg2,
  output logic [7:0]  bg3,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, VID, CPU_WR, CPU_RD, CPU_RDD} state_t;

  localparam logic [2:0] LAST_PLANE = 3'(NPLANES - 1);

  state_t      state, state_n;
  logic [2:0]  plane, plane_n;
  logic        start_fetch;
  logic        new_cell;
  logic [12:0] lat_addr;
  logic [12:0] fetch_addr;
  logic        fetch_pend;
  logic        stage_valid;
  logic        armed;
  logic        cap_valid;
  logic [2:0]  cap_idx;
  logic [7:0]  staging [NPLANES];

  logic [15:0] addr_n;
  logic [7:0]  wdata_n;
  logic        rd_n, wr_n, ack_n;

  always_comb begin
    new_cell   = cell_start & fetch_en;
    fetch_addr = new_cell ? cell_addr : lat_addr;
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      plane <= '0;
    end else begin
      state <= state_n;
      plane <= plane_n;
    end
  end

  // Next-state logic: video beats CPU in IDLE, and a new cell restarts a fetch in flight
  always_comb begin
    state_n     = state;
    plane_n     = plane;
    start_fetch = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_pend || new_cell) begin
          state_n     = VID;
          plane_n     = '0;
          start_fetch = 1'b1;
        end else if (bus.cpu_req) begin
          state_n = bus.cpu_we ? CPU_WR : CPU_RD;
        end
      end
      VID: begin
        if (cell_start) begin
          if (fetch_en) begin
            plane_n     = '0;
            start_fetch = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (plane == LAST_PLANE) begin
          state_n = IDLE;
        end else begin
          plane_n = plane + 3'd1;
        end
      end
      CPU_WR:  state_n = IDLE;
      CPU_RD:  state_n = CPU_RDD;
      CPU_RDD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: the bus value for the upcoming state, registered below
  always_comb begin
    addr_n  = bus.vram_addr;
    wdata_n = bus.vram_wdata;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    ack_n   = 1'b0;
    case (state_n)
      VID: begin
        addr_n = 16'(PLANE_BASE) + 16'(PLANE_SIZE) * 16'(plane_n) + 16'(fetch_addr);
        rd_n   = 1'b1;
      end
      CPU_WR: begin
        addr_n  = bus.cpu_addr;
        wdata_n = bus.cpu_wdata;
        wr_n    = 1'b1;
        ack_n   = 1'b1;
      end
      CPU_RD: begin
        addr_n = bus.cpu_addr;
        rd_n   = 1'b1;
      end
      default: ;
    endcase
    if (state == CPU_RDD) ack_n = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.vram_addr  <= '0;
      bus.vram_rd    <= 1'b0;
      bus.vram_wr    <= 1'b0;
      bus.vram_wdata <= '0;
      bus.cpu_rdata  <= '0;
      bus.cpu_ack    <= 1'b0;
    end else begin
      bus.vram_addr  <= addr_n;
      bus.vram_rd    <= rd_n;
      bus.vram_wr    <= wr_n;
      bus.vram_wdata <= wdata_n;
      bus.cpu_ack    <= ack_n;
      if (state == CPU_RDD) bus.cpu_rdata <= bus.vram_rdata;
    end
  end

  // Staging datapath: a slot's byte lands one clk after the slot. Any cell_start
  // cancels the capture in flight, so staging never mixes bytes from two cells.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lat_addr    <= '0;
      fetch_pend  <= 1'b0;
      armed       <= 1'b0;
      overrun     <= 1'b0;
      cap_valid   <= 1'b0;
      cap_idx     <= '0;
      stage_valid <= 1'b0;
      fg1 <= '0; fg2 <= '0; fg3 <= '0;
      bg1 <= '0; bg2 <= '0; bg3 <= '0;
      for (int unsigned i = 0; i < NPLANES; i++) staging[i] <= '0;
    end else begin
      if (new_cell) lat_addr <= cell_addr;
      fetch_pend <= start_fetch ? 1'b0 : (fetch_pend | new_cell);
      if (cell_start) armed <= fetch_en;
      overrun   <= cell_start & ~stage_valid & armed;
      cap_valid <= (state == VID) & ~cell_start;
      cap_idx   <= plane;
      if (cell_start) begin
        if (stage_valid) begin
          fg1 <= staging[0];
          fg2 <= staging[1];
          fg3 <= staging[2];
          bg1 <= staging[3];
          bg2 <= staging[4];
          bg3 <= staging[5];
        end
        stage_valid <= 1'b0;
      end else if (cap_valid) begin
        staging[cap_idx] <= bus.vram_rdata;
        if (cap_idx == LAST_PLANE) stage_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_fetch_arb.sv
// Directed bench for vram_fetch_arb with a registered-read VRAM model.
module tb_vram_fetch_arb;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cell_start = 1'b0;
  logic        fetch_en = 1'b0;
  logic [12:0] cell_addr = '0;
  logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
  logic        overrun;

  vram_fetch_arb_if bus();

  vram_fetch_arb #(.PLANE_BASE('h0000), .PLANE_SIZE('h2000), .NPLANES(6)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .cell_start(cell_start),
    .fetch_en  (fetch_en),
    .cell_addr (cell_addr),
    .bus       (bus.master),
    .fg1(fg1), .fg2(fg2), .fg3(fg3),
    .bg1(bg1), .bg2(bg2), .bg3(bg3),
    .overrun   (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int passed = 0;
  int rd_cnt = 0, ack_cnt = 0, ovr_cnt = 0, both_cnt = 0;
  logic [7:0] mem [65536];

  wire [47:0] planes = {fg1, fg2, fg3, bg1, bg2, bg3};

  // VRAM model: cells 'h0ec0 hold 'h10+p, cells 'h0100 hold 'h20+p, 'h1234 holds 'hc3
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int p = 0; p < 6; p++) begin
        mem[16'(p * 'h2000 + 'h0ec0)] = 8'(8'h10 + p);
        mem[16'(p * 'h2000 + 'h0100)] = 8'(8'h20 + p);
      end
      mem[16'h1234] = 8'hc3;
    end else begin
      if (bus.vram_rd) bus.vram_rdata <= mem[bus.vram_addr];
      if (bus.vram_wr) mem[bus.vram_addr] = bus.vram_wdata;
    end
  end

  always @(posedge clk_sys) begin
    if (bus.vram_rd) rd_cnt <= rd_cnt + 1;
    if (bus.cpu_ack) ack_cnt <= ack_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (bus.vram_rd && bus.vram_wr) both_cnt <= both_cnt + 1;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
    lat = 0;
    while (lat < 10) begin
      tick();
      lat++;
      if (bus.cpu_ack) break;
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output int lat);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    lat = 0;
    d = 8'h00;
    while (lat < 10) begin
      tick();
      lat++;
      if (bus.cpu_ack) begin
        d = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    int r0;
    reset_n = 1'b0; fetch_en = 1'b1; cell_addr = 13'h0ec0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cell_start = ~cell_start;
    end
    total++; if (bus.vram_addr !== 16'h0) $display("FAIL reset_addr: got %h exp 0000", bus.vram_addr); else passed++;
    total++; if ({bus.vram_rd, bus.vram_wr} !== 2'b00) $display("FAIL reset_strobes: got %b exp 00", {bus.vram_rd, bus.vram_wr}); else passed++;
    total++; if (bus.vram_wdata !== 8'h0) $display("FAIL reset_wdata: got %h exp 00", bus.vram_wdata); else passed++;
    total++; if ({bus.cpu_ack, bus.cpu_rdata} !== 9'h0) $display("FAIL reset_cpu: got %h exp 000", {bus.cpu_ack, bus.cpu_rdata}); else passed++;
    total++; if (planes !== 48'h0) $display("FAIL reset_planes: got %h exp 0", planes); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", overrun); else passed++;
    cell_start = 1'b0; fetch_en = 1'b0; reset_n = 1'b1;
    r0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      cell_start = (i % 3 == 0);
    end
    cell_start = 1'b0;
    tick(); tick();
    total++; if (rd_cnt - r0 !== 0) $display("FAIL blank_no_rd: got %0d exp 0", rd_cnt - r0); else passed++;
    total++; if (ovr_cnt !== 0) $display("FAIL blank_no_overrun: got %0d exp 0", ovr_cnt); else passed++;
  endtask

  task automatic test_video_fetch;
    logic [15:0] exp;
    cell_addr = 13'h0ec0; fetch_en = 1'b1; cell_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      cell_start = 1'b0;
      exp = 16'(16'h0ec0 + (k - 1) * 16'h2000);
      total++;
      if ({bus.vram_rd, bus.vram_addr} !== {1'b1, exp})
        $display("FAIL fetch_slot%0d: got rd=%b addr=%h exp rd=1 addr=%h", k, bus.vram_rd, bus.vram_addr, exp);
      else passed++;
    end
    tick();
    total++; if (bus.vram_rd !== 1'b0) $display("FAIL fetch_end_rd: got %b exp 0", bus.vram_rd); else passed++;
    for (int k = 8; k <= 12; k++) tick();
    cell_start = 1'b1;
    tick();
    cell_start = 1'b0;
    total++; if (planes !== 48'h101112131415) $display("FAIL fetch_planes: got %h exp 101112131415", planes); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL fetch_overrun: got %b exp 0", overrun); else passed++;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_cpu_write_priority;
    int a0, nrd, lat;
    logic got_wr;
    logic [7:0] d;
    a0 = ack_cnt; nrd = 0; got_wr = 1'b0;
    cell_addr = 13'h0ec0; fetch_en = 1'b1; cell_start = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h3000; bus.cpu_wdata = 8'h5a;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cell_start = 1'b0;
      if (bus.vram_wr && !got_wr) begin
        got_wr = 1'b1;
        total++; if (nrd !== 6) $display("FAIL wr_after_video: got %0d reads before write exp 6", nrd); else passed++;
        total++; if ({bus.vram_addr, bus.vram_wdata} !== {16'h3000, 8'h5a})
          $display("FAIL wr_bus: got %h/%h exp 3000/5a", bus.vram_addr, bus.vram_wdata); else passed++;
        total++; if (bus.cpu_ack !== 1'b1) $display("FAIL wr_ack_same_clk: got %b exp 1", bus.cpu_ack); else passed++;
        bus.cpu_req = 1'b0;
      end
      if (bus.vram_rd) nrd++;
    end
    bus.cpu_req = 1'b0;
    total++; if (got_wr !== 1'b1) $display("FAIL wr_seen: got %b exp 1", got_wr); else passed++;
    total++; if (ack_cnt - a0 !== 1) $display("FAIL wr_ack_count: got %0d exp 1", ack_cnt - a0); else passed++;
    cpu_read(16'h3000, d, lat);
    total++; if (d !== 8'h5a) $display("FAIL readback_data: got %h exp 5a", d); else passed++;
    total++; if (lat !== 3) $display("FAIL readback_latency: got %0d exp 3", lat); else passed++;
    tick();
  endtask

  task automatic test_read_during_cell;
    int r0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    tick();
    total++; if ({bus.vram_rd, bus.vram_wr, bus.vram_addr} !== {2'b10, 16'h1234})
      $display("FAIL rd_addr_cycle: got %b%b %h exp 10 1234", bus.vram_rd, bus.vram_wr, bus.vram_addr); else passed++;
    cell_start = 1'b1; fetch_en = 1'b1; cell_addr = 13'h0100;
    tick();
    cell_start = 1'b0;
    total++; if (bus.cpu_ack !== 1'b0) $display("FAIL rd_early_ack: got %b exp 0", bus.cpu_ack); else passed++;
    tick();
    total++; if (bus.cpu_ack !== 1'b1) $display("FAIL rd_ack: got %b exp 1", bus.cpu_ack); else passed++;
    total++; if (bus.cpu_rdata !== 8'hc3) $display("FAIL rd_data: got %h exp c3", bus.cpu_rdata); else passed++;
    bus.cpu_req = 1'b0;
    tick();
    total++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 16'h0100})
      $display("FAIL rd_then_fetch: got rd=%b addr=%h exp rd=1 addr=0100", bus.vram_rd, bus.vram_addr); else passed++;
    r0 = rd_cnt;
    for (int k = 0; k < 7; k++) tick();
    total++; if (rd_cnt - r0 !== 6) $display("FAIL rd_fetch_reads: got %0d exp 6", rd_cnt - r0); else passed++;
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_cnt;
    cell_addr = 13'h0ec0; fetch_en = 1'b1; cell_start = 1'b1;
    tick();
    cell_start = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_first: got %b exp 0", overrun); else passed++;
    total++; if (planes !== 48'h202122232425) $display("FAIL ovr_first_planes: got %h exp 202122232425", planes); else passed++;
    for (int n = 1; n <= 3; n++) begin
      for (int k = 0; k < 4; k++) tick();
      cell_start = 1'b1;
      tick();
      cell_start = 1'b0;
      total++; if (overrun !== 1'b1) $display("FAIL ovr_pulse%0d: got %b exp 1", n, overrun); else passed++;
      total++; if (planes !== 48'h202122232425) $display("FAIL ovr_hold%0d: got %h exp 202122232425", n, planes); else passed++;
    end
    tick();
    total++; if (overrun !== 1'b0) $display("FAIL ovr_one_clk: got %b exp 0", overrun); else passed++;
    total++; if (ovr_cnt - o0 !== 3) $display("FAIL ovr_count: got %0d exp 3", ovr_cnt - o0); else passed++;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_blanking;
    int r0, o0, maxlat;
    r0 = rd_cnt; o0 = ovr_cnt; maxlat = 0;
    fork
      begin
        for (int c = 0; c < 3; c++) begin
          cell_start = 1'b1; fetch_en = 1'b0;
          tick();
          cell_start = 1'b0;
          for (int k = 0; k < 11; k++) tick();
        end
      end
      begin
        int lat;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
          cpu_write(16'(16'h0200 + i), 8'(8'h80 + i), lat);
          if (lat > maxlat) maxlat = lat;
          tick();
          cpu_read(16'(16'h0200 + i), d, lat);
          if (lat > maxlat) maxlat = lat;
          total++; if (d !== 8'(8'h80 + i)) $display("FAIL blank_rd%0d: got %h exp %h", i, d, 8'(8'h80 + i)); else passed++;
          tick();
        end
      end
    join
    tick();
    total++; if (maxlat > 3) $display("FAIL blank_latency: got %0d exp <=3", maxlat); else passed++;
    total++; if (rd_cnt - r0 !== 6) $display("FAIL blank_video_rd: got %0d reads exp 6 (cpu only)", rd_cnt - r0); else passed++;
    total++; if (ovr_cnt - o0 !== 0) $display("FAIL blank_overrun: got %0d exp 0", ovr_cnt - o0); else passed++;
    total++; if (planes !== 48'h101112131415) $display("FAIL blank_planes: got %h exp 101112131415", planes); else passed++;
  endtask

  task automatic test_reset_mid;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    total++; if ({bus.cpu_ack, bus.vram_rd, bus.vram_addr} !== 18'h0)
      $display("FAIL midreset_bus: got ack=%b rd=%b addr=%h exp 0", bus.cpu_ack, bus.vram_rd, bus.vram_addr); else passed++;
    total++; if (planes !== 48'h0) $display("FAIL midreset_planes: got %h exp 0", planes); else passed++;
    tick();
    total++; if ({bus.cpu_ack, bus.cpu_rdata} !== 9'h0) $display("FAIL midreset_ack_lost: got %h exp 000", {bus.cpu_ack, bus.cpu_rdata}); else passed++;
    bus.cpu_req = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vram_rdata = '0;
    test_reset();
    test_video_fetch();
    test_cpu_write_priority();
    test_read_during_cell();
    test_overrun();
    test_blanking();
    test_reset_mid();
    total++; if (both_cnt !== 0) $display("FAIL strobe_exclusive: got %0d clks with rd and wr exp 0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end
endmodule
